alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Multi-cycle integer execute unit that consumes the 4-bit ALUControl code produced by the ALU control decoder and performs the operation on two XLEN operands. It sits in the EX stage between the decoder/register-read logic and writeback. It accepts one operation at a time through a valid/ready handshake and returns a registered result and zero flag; BEQ resolution uses SUB plus the zero flag. Shifts run iteratively, one bit per cycle, unless the fast-shift option is compiled in.

## Interface
- XLEN, 64, operand/result width (power of two, ≥8)
- SHW, $clog2(XLEN), shift-amount width (derived; do not override)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request this cycle
- alu_control  in  4  operation code {funct7 bit, funct3}
- op_a  in  XLEN  operand A
- op_b  in  XLEN  operand B; op_b[SHW-1:0] is the shift amount
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- result  out  XLEN  operation result
- zero  out  1  result == 0
- illegal  out  1  alu_control was not a supported code

## Operation
- Codes:
  - 0000 ADD
  - 1000 SUB
  - 0111 AND
  - 0110 OR
  - 0100 XOR
  - 0010 SLT (signed)
  - 0011 SLTU
  - 0001 SLL
  - 0101 SRL
  - 1101 SRA
  - Any other code: result=0, zero=1, illegal=1.
- Arithmetic is modulo 2^XLEN; the carry is discarded. SLT/SLTU write 1 or 0 zero-extended.
- Transfer rule: a request is accepted when in_valid && in_ready at a rising edge. Operands and code are latched on acceptance and are not sampled afterwards.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational and allows back-to-back issue when the output is drained in the same cycle.
- FSM states:
  - IDLE → EXEC on acceptance of a shift with shamt≠0.
  - IDLE → IDLE on acceptance of any other op; the result is loaded directly.
  - EXEC: shift the working register by 1 bit per cycle and decrement the counter. When the counter reaches 0, load result, set out_valid, and return to IDLE.
- Shift fill: SRA replicates the latched op_a[XLEN-1]; SLL and SRL fill with 0.
- Output hold: while out_valid && !out_ready, result, zero and illegal hold their values and in_ready=0.
- out_valid clears on out_ready unless a new result loads in the same cycle.
- Reset: the FSM goes to IDLE immediately. out_valid=0, result=0, zero=0, illegal=0, counter=0, and any in-flight shift is discarded. After reset deasserts, in_ready=1 in the first cycle.

## Timing
- Non-shift op, or shift with shamt=0: accepted at edge N → out_valid=1 after edge N+1... registered at edge N, visible in cycle N+1. Latency is 1 cycle.
- Iterative shift with shamt=k>0: accepted at edge N → out_valid visible after edge N+k, with k cycles in EXEC. in_ready=0 for those cycles.
- The maximum shift latency is XLEN-1 cycles.
- zero and illegal change only on the edge that loads result.
- A new request is accepted on the same edge as out_ready consumption: the old result leaves and the new one appears the next cycle, with no bubble.
- in_valid while in_ready=0 is ignored. The requester must hold the request until it is accepted.

## Configuration
- ALU_FAST_SHIFT_EN
  - Defined: shifts use a single-cycle barrel shifter, EXEC is never entered, and every supported op has 1-cycle latency.
  - Undefined: iterative shifting as described above. All other behaviour, handshake and reset values are identical in both builds.

## Test plan
- Reset, then issue ADD with a=5, b=7 → after 1 cycle out_valid=1, result=12, zero=0, illegal=0.
- BEQ path, SUB with a=b=0x1234 → result=0, zero=1. SUB with a=3, b=5 → result=0xFFFF_FFFF_FFFF_FFFE.
- SRA with a=0x8000_0000_0000_0000, b=4:
  - Without ALU_FAST_SHIFT_EN → in_ready=0 for 4 cycles, then result=0xF800_0000_0000_0000.
  - With the macro defined → same result after 1 cycle.
- Backpressure: hold out_ready=0 after an AND result (a=0xF0, b=0x3C → 0x30) → result stays 0x30 and in_ready=0. Then pulse out_ready together with in_valid for OR (0xF0 | 0x0F) → next cycle result=0xFF with no idle cycle.
- Code 1111 with any operands → result=0, zero=1, illegal=1. The next legal ADD clears illegal.
- Assert rst 2 cycles into an SLL with shamt=10 → out_valid=0 and result=0 immediately. No stale result appears after reset deasserts.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Multi-cycle integer execute unit: valid/ready in, registered result/zero/illegal out.
// Shifts iterate one bit per cycle unless ALU_FAST_SHIFT_EN selects a barrel shifter.
module alu_exec_unit #(
  parameter int XLEN = 64,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef enum logic {IDLE, EXEC} state_t;

  state_t            state_reg, state_next;
  logic [XLEN-1:0]   work_reg;
  logic [SHW-1:0]    cnt_reg;
  logic              right_reg;
  logic              fill_reg;

  logic [SHW-1:0]    shamt;
  logic              accept;
  logic              is_shift;
  logic [XLEN-1:0]   op_result;
  logic              op_illegal;
  logic [XLEN-1:0]   step_left;
  logic [XLEN-1:0]   step_right;
  logic [XLEN-1:0]   step_val;
  logic              load;
  logic              start_shift;
  logic [XLEN-1:0]   load_val;
  logic              load_ill;

  assign shamt    = op_b[SHW-1:0];
  assign in_ready = (state_reg == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_shift = (alu_control == 4'b0001) || (alu_control == 4'b0101) ||
                    (alu_control == 4'b1101);

  always_comb begin
    op_result  = '0;
    op_illegal = 1'b0;
    case (alu_control)
      4'b0000: op_result = op_a + op_b;
      4'b1000: op_result = op_a - op_b;
      4'b0111: op_result = op_a & op_b;
      4'b0110: op_result = op_a | op_b;
      4'b0100: op_result = op_a ^ op_b;
      4'b0010: op_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b0011: op_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
`ifdef ALU_FAST_SHIFT_EN
      4'b0001: op_result = op_a << shamt;
      4'b0101: op_result = op_a >> shamt;
      4'b1101: op_result = $unsigned($signed(op_a) >>> shamt);
`else
      // Only reached with shamt == 0; nonzero shifts take the EXEC path.
      4'b0001, 4'b0101, 4'b1101: op_result = op_a;
`endif
      default: op_illegal = 1'b1;
    endcase
  end

  // One-bit shift network for the iterative path.
  generate
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_step
      if (gi == 0) begin : g_lo
        assign step_left[gi] = 1'b0;
      end else begin : g_lo
        assign step_left[gi] = work_reg[gi-1];
      end
      if (gi == XLEN-1) begin : g_hi
        assign step_right[gi] = fill_reg;
      end else begin : g_hi
        assign step_right[gi] = work_reg[gi+1];
      end
    end
  endgenerate

  assign step_val = right_reg ? step_right : step_left;

  always_comb begin
    state_next  = state_reg;
    load        = 1'b0;
    start_shift = 1'b0;
    load_val    = op_result;
    load_ill    = op_illegal;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (!FAST && is_shift && (shamt != '0)) begin
            start_shift = 1'b1;
            state_next  = EXEC;
          end else begin
            load = 1'b1;
          end
        end
      end
      EXEC: begin
        if (cnt_reg == SHW'(1)) begin
          load       = 1'b1;
          load_val   = step_val;
          load_ill   = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      cnt_reg   <= '0;
      right_reg <= 1'b0;
      fill_reg  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_shift) begin
        work_reg  <= op_a;
        cnt_reg   <= shamt;
        right_reg <= alu_control[2];
        fill_reg  <= alu_control[3] & op_a[XLEN-1];
      end else if (state_reg == EXEC) begin
        work_reg <= step_val;
        cnt_reg  <= cnt_reg - SHW'(1);
      end
      if (load) begin
        result    <= load_val;
        zero      <= (load_val == '0);
        illegal   <= load_ill;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit; expected values are hand-computed.
// Shift latency expectations follow ALU_FAST_SHIFT_EN.
module tb_alu_exec_unit;
  localparam int XLEN = 64;
`ifdef ALU_FAST_SHIFT_EN
  localparam int SLOW = 0;
`else
  localparam int SLOW = 1;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  int tests = 0;
  int fails = 0;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Issues one request, scrambles the inputs after acceptance, waits for out_valid.
  task automatic run_op(input string tag, input logic [3:0] code,
                        input logic [63:0] a, input logic [63:0] b,
                        output int wait_cnt, output int busy);
    check({tag, ".rdy"}, 64'(in_ready), 64'd1);
    alu_control = code;
    op_a        = a;
    op_b        = b;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    op_a        = ~a;
    op_b        = ~b;
    alu_control = ~code;
    wait_cnt    = 0;
    busy        = 0;
    while (!out_valid && wait_cnt < 200) begin
      if (!in_ready) busy++;
      @(posedge clk); #1;
      wait_cnt++;
    end
  endtask

  task automatic check_op(input string tag, input logic [3:0] code,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input int exp_wait,
                          input logic exp_ill);
    int w, bsy;
    run_op(tag, code, a, b, w, bsy);
    check({tag, ".wait"}, 64'(w), 64'(exp_wait));
    check({tag, ".res"}, result, exp_res);
    check({tag, ".zero"}, 64'(zero), 64'(exp_res == 64'd0));
    check({tag, ".ill"}, 64'(illegal), 64'(exp_ill));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, bsy, stale;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_control = 4'h0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.res", result, 64'd0);
    check("rst.zero", 64'(zero), 64'd0);
    check("rst.ill", 64'(illegal), 64'd0);
    rst = 1'b0;
    #1;
    check("rst.ready", 64'(in_ready), 64'd1);

    check_op("add", 4'b0000, 64'd5, 64'd7, 64'd12, 0, 1'b0);
    check_op("beq", 4'b1000, 64'h1234, 64'h1234, 64'd0, 0, 1'b0);
    check_op("sub", 4'b1000, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1'b0);
    check_op("xor", 4'b0100, 64'hFF00, 64'h0FF0, 64'hF0F0, 0, 1'b0);
    check_op("slt", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 0, 1'b0);
    check_op("sltu", 4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0, 1'b0);
    check_op("sll0", 4'b0001, 64'hABC, 64'd0, 64'hABC, 0, 1'b0);

    run_op("sra", 4'b1101, 64'h8000_0000_0000_0000, 64'd4, w, bsy);
    check("sra.wait", 64'(w), 64'(4 * SLOW));
    check("sra.busy", 64'(bsy), 64'(4 * SLOW));
    check("sra.res", result, 64'hF800_0000_0000_0000);
    check_op("srl", 4'b0101, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 4 * SLOW, 1'b0);
    check_op("sll63", 4'b0001, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 63 * SLOW, 1'b0);

    // Backpressure: result must hold, then a same-edge drain/issue.
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_op("and", 4'b0111, 64'hF0, 64'h3C, 64'h30, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("hold.res", result, 64'h30);
    check("hold.valid", 64'(out_valid), 64'd1);
    check("hold.ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    alu_control = 4'b0110; op_a = 64'hF0; op_b = 64'h0F; in_valid = 1'b1;
    #1;
    check("or.ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("or.valid", 64'(out_valid), 64'd1);
    check("or.res", result, 64'hFF);

    check_op("illegal", 4'b1111, 64'd7, 64'd9, 64'd0, 0, 1'b1);
    check_op("add2", 4'b0000, 64'd1, 64'd1, 64'd2, 0, 1'b0);

    // Reset in the middle of an SLL by 10.
    alu_control = 4'b0001; op_a = 64'd1; op_b = 64'd10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid.valid", 64'(out_valid), 64'd0);
    check("mid.res", result, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    stale = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("mid.stale", 64'(stale), 64'd0);
    check_op("add3", 4'b0000, 64'd5, 64'd7, 64'd12, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
